slow_peripheral_responder: RTL and testbench
============================================

SLOW_PERIPHERAL_RESPONDER -- requirements
Module: slow_peripheral_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, wait cycles inserted before each transfer is accepted (range 0..7).
REQ-002 SHALL have parameter READ_LATENCY, default 2, cycles from read acceptance to readdatavalid (range 1..4).
REQ-003 SHALL have parameter MAX_PENDING, default 4, maximum outstanding accepted reads (range 1..4).
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  8  byte address; bits [7:2] select the word, bits [1:0] are ignored.
REQ-007 byteenable  input  4  write byte lanes.
REQ-008 read  input  1  read request.
REQ-009 write  input  1  write request.
REQ-010 writedata  input  32  write data.
REQ-011 waitrequest  output  1  stall; the transfer is accepted in the cycle where (read|write) & !waitrequest.
REQ-012 readdata  output  32  read response data.
REQ-013 readdatavalid  output  1  one-cycle qualifier for readdata and endofpacket.
REQ-014 endofpacket  output  1  marks the last word of the scratch file.

Function
REQ-015 Register map:
- Words 0..15: 32-bit read/write scratch registers.
- Word 16: read-only free-running 32-bit cycle counter that wraps 0xFFFFFFFF->0.
- Word 17: status {read_count[15:0], write_count[15:0]}; any write to word 17 clears both counts.
- Words 18..63: unmapped.
REQ-016 Wait counter wcnt SHALL count 0..WAIT_STATES while read|write is high and the transfer is not yet accepted; wcnt SHALL clear on acceptance and whenever read|write is low.
REQ-017 waitrequest SHALL equal (read|write) & ((wcnt != WAIT_STATES) | (read & pending == MAX_PENDING)); it is combinational and 0 when the bus is idle.
REQ-018 With WAIT_STATES=0 and pending < MAX_PENDING, a transfer SHALL be accepted in its first cycle.
REQ-019 An accepted write SHALL update each byte lane whose byteenable bit is 1, at that clock edge, for words 0..15.
- Writes to word 16 and to words 18..63 SHALL be ignored.
REQ-020 An accepted read SHALL sample the addressed word at the acceptance edge.
- The value SHALL appear on readdata with readdatavalid=1 exactly READ_LATENCY cycles later, for one cycle.
- Responses SHALL be returned in order.
REQ-021 Reads of words 18..63 SHALL return 0x00000000 with normal latency.
REQ-022 endofpacket SHALL be 1 only with readdatavalid, and only for a read of word 15.
REQ-023 readdata SHALL be 0 whenever readdatavalid is 0.
REQ-024 pending (3 bits) SHALL increment on read acceptance and decrement on readdatavalid; when both happen in the same cycle it SHALL be unchanged.
REQ-025 A read accepted while pending == MAX_PENDING is impossible, because waitrequest stays high until a response retires.
REQ-026 write_count and read_count SHALL increment on write and read acceptance respectively, wrapping at 16 bits.
- A write to word 17 SHALL clear both counts and SHALL NOT itself be counted.
REQ-027 If read and write are both high, only the write SHALL be performed; no read response is generated and the cycle counts as a write.
REQ-028 A write accepted in cycle T SHALL be visible to any read accepted in cycle T+1 or later.
REQ-029 Changing address or data while waitrequest=1 SHALL restart nothing; the values present at acceptance are used.

Reset
REQ-030 While reset_n=0:
- waitrequest SHALL be 1 if read|write, else 0.
- readdata, readdatavalid, endofpacket, wcnt, pending, both counts, the cycle counter and all scratch registers SHALL be 0.
REQ-031 Assertion of reset_n mid-operation SHALL discard all pending reads; no readdatavalid is produced for reads accepted before reset.
REQ-032 The first transfer after reset_n deasserts SHALL see wcnt=0 and the full WAIT_STATES delay.

Verification
REQ-033 Defaults; write word 3 = 0x12345678, be=0xF -> waitrequest high for 2 cycles, accepted on cycle 3; a read of word 3 returns 0x12345678 with readdatavalid 2 cycles after acceptance, endofpacket=0.
REQ-034 Write word 15 = 0xAABBCCDD, then write 0x00000011 with be=0x1, then read word 15 -> readdata 0xAABBCC11, endofpacket=1.
REQ-035 WAIT_STATES=0, READ_LATENCY=4, MAX_PENDING=2; back-to-back reads of words 0,1,2 -> the third read stalls until the first response, and responses arrive in order.
REQ-036 Perform 3 writes and 2 reads, then read word 17 -> 0x00020003; then write word 17 and read word 17 -> 0x00000000.
REQ-037 Reset asserted one cycle after a read is accepted -> no readdatavalid afterwards; scratch registers read back 0.
REQ-038 Read word 40 -> 0x00000000; write word 16 then read word 16 -> counter value unaffected by the write, increasing monotonically.

Source files
------------

// File: rtl/slow_peripheral_responder.sv
// slow_peripheral_responder: wait-stated scratch/counter/status slave
// with fixed-latency, in-order, pipelined read responses.
module slow_peripheral_responder #(
  parameter int WAIT_STATES  = 2,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  address,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        endofpacket
);
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  localparam logic [2:0] MP = 3'(MAX_PENDING);
  localparam int         LAST = READ_LATENCY - 1;

  typedef struct packed {
    logic        vld;
    logic        eop;
    logic [31:0] data;
  } rsp_t;

  logic [2:0]  wcnt_q, wcnt_d;
  logic [2:0]  pend_q, pend_d;
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] regs_q [16];
  logic [31:0] regs_d [16];
  rsp_t        pipe_q [READ_LATENCY];
  rsp_t        pipe_d [READ_LATENCY];

  logic [5:0]  word;
  logic        req;
  logic        acc;
  logic        wr_acc;
  logic        rd_acc;
  logic        rsp_out;
  logic [31:0] rd_word;
  logic        unused_addr;

  assign word        = address[7:2];
  assign unused_addr = ^address[1:0];
  assign req         = read | write;

  // Reset and full response pipe both hold off the bus.
  assign waitrequest = req & (~reset_n | (wcnt_q != WS) |
                              (read & (pend_q == MP)));

  assign acc     = req & ~waitrequest;
  assign wr_acc  = acc & write;
  assign rd_acc  = acc & read & ~write;
  assign rsp_out = pipe_q[LAST].vld;

  assign readdatavalid = rsp_out;
  assign readdata      = pipe_q[LAST].data;
  assign endofpacket   = pipe_q[LAST].eop;

  // Register map decode for the read sample.
  always_comb begin
    rd_word = '0;
    if (word < 6'd16) begin
      rd_word = regs_q[word[3:0]];
    end else if (word == 6'd16) begin
      rd_word = cyc_q;
    end else if (word == 6'd17) begin
      rd_word = {rd_cnt_q, wr_cnt_q};
    end
  end

  // Next state: wait counter, pending, counters, scratch, read pipe.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!req || acc) begin
      wcnt_d = '0;
    end else if (wcnt_q != WS) begin
      wcnt_d = wcnt_q + 3'd1;
    end
    pend_d   = pend_q + {2'b0, rd_acc} - {2'b0, rsp_out};
    cyc_d    = cyc_q + 32'd1;
    rd_cnt_d = rd_cnt_q + {15'b0, rd_acc};
    wr_cnt_d = wr_cnt_q;
    regs_d   = regs_q;
    if (wr_acc) begin
      if (word == 6'd17) begin
        rd_cnt_d = '0;
        wr_cnt_d = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end
      if (word < 6'd16) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) begin
            regs_d[word[3:0]][8*b +: 8] = writedata[8*b +: 8];
          end
        end
      end
    end
    pipe_d[0].vld  = rd_acc;
    pipe_d[0].eop  = rd_acc & (word == 6'd15);
    pipe_d[0].data = rd_acc ? rd_word : 32'h0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // State registers; reset drops every in-flight response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q   <= '0;
      pend_q   <= '0;
      cyc_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      regs_q   <= '{default: '0};
      pipe_q   <= '{default: '0};
    end else begin
      wcnt_q   <= wcnt_d;
      pend_q   <= pend_d;
      cyc_q    <= cyc_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      regs_q   <= regs_d;
      pipe_q   <= pipe_d;
    end
  end

endmodule

// File: tb/tb_slow_peripheral_responder.sv
// tb_slow_peripheral_responder: directed table, corner sequences and
// random traffic against a transaction-level reference model.
module tb_slow_peripheral_responder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_i   [2];
  logic        wr_i   [2];
  logic [7:0]  ad_i   [2];
  logic [3:0]  be_i   [2];
  logic [31:0] wd_i   [2];
  logic        wq_o   [2];
  logic [31:0] rdat_o [2];
  logic        rdv_o  [2];
  logic        eop_o  [2];

  always #5 clk = ~clk;

  slow_peripheral_responder dut0 (
    .clk(clk), .reset_n(reset_n), .address(ad_i[0]),
    .byteenable(be_i[0]), .read(rd_i[0]), .write(wr_i[0]),
    .writedata(wd_i[0]), .waitrequest(wq_o[0]),
    .readdata(rdat_o[0]), .readdatavalid(rdv_o[0]),
    .endofpacket(eop_o[0])
  );

  slow_peripheral_responder #(
    .WAIT_STATES(0), .READ_LATENCY(4), .MAX_PENDING(2)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(ad_i[1]),
    .byteenable(be_i[1]), .read(rd_i[1]), .write(wr_i[1]),
    .writedata(wd_i[1]), .waitrequest(wq_o[1]),
    .readdata(rdat_o[1]), .readdatavalid(rdv_o[1]),
    .endofpacket(eop_o[1])
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        eop;
  } exp_rsp_t;

  typedef struct {
    logic [31:0] data;
    logic        eop;
  } obs_t;

  typedef struct {
    logic        r;
    logic        w;
    logic [7:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] exp;
    logic        eop;
  } vec_t;

  exp_rsp_t    rq [$];
  obs_t        obs_q [$];
  vec_t        tbl [$];
  logic [31:0] m_regs [16];
  logic [15:0] m_rc;
  logic [15:0] m_wc;
  logic [31:0] m_cyc;
  int now, waited, ws, rl, mp, cur;
  int n_cmp, n_bad;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %08h want %08h at %0t",
               nm, cur, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [7:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    rd_i[cur] = r;
    wr_i[cur] = w;
    ad_i[cur] = a;
    be_i[cur] = be;
    wd_i[cur] = d;
  endtask

  task automatic model_clear();
    rq.delete();
    obs_q.delete();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_rc   = 16'h0;
    m_wc   = 16'h0;
    m_cyc  = 32'h0;
    waited = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] w);
    if (w < 6'd16) return m_regs[w[3:0]];
    if (w == 6'd16) return m_cyc;
    if (w == 6'd17) return {m_rc, m_wc};
    return 32'h0;
  endfunction

  // One bus cycle: entered just after a falling edge with inputs driven.
  task automatic step(output logic acc);
    logic        r, w, req, ew, er;
    logic [5:0]  wsel;
    logic [3:0]  be;
    logic [31:0] d;
    r    = rd_i[cur];
    w    = wr_i[cur];
    req  = r | w;
    wsel = ad_i[cur][7:2];
    be   = be_i[cur];
    d    = wd_i[cur];
    #1;
    ew = req && ((waited < ws) || (r && rq.size() >= mp));
    chk("waitrequest", {31'b0, wq_o[cur]}, {31'b0, ew});
    er = 1'b0;
    if (rq.size() > 0) er = (rq[0].due == now);
    chk("readdatavalid", {31'b0, rdv_o[cur]}, {31'b0, er});
    chk("readdata", rdat_o[cur], er ? rq[0].data : 32'h0);
    chk("endofpacket", {31'b0, eop_o[cur]},
        {31'b0, er ? rq[0].eop : 1'b0});
    if (rdv_o[cur]) obs_q.push_back('{data: rdat_o[cur], eop: eop_o[cur]});
    if (er) void'(rq.pop_front());
    acc = req && !ew;
    if (acc && w) begin
      if (wsel < 6'd16) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_regs[wsel[3:0]][8*b +: 8] = d[8*b +: 8];
      end
      if (wsel == 6'd17) begin
        m_rc = 16'h0;
        m_wc = 16'h0;
      end else begin
        m_wc = m_wc + 16'd1;
      end
    end else if (acc) begin
      rq.push_back('{due: now + rl, data: m_read(wsel),
                     eop: (wsel == 6'd15)});
      m_rc = m_rc + 16'd1;
    end
    waited = (req && !acc) ? waited + 1 : 0;
    @(negedge clk);
    now++;
    m_cyc = m_cyc + 32'd1;
  endtask

  task automatic xfer(input logic r, input logic w, input logic [7:0] a,
                      input logic [3:0] be, input logic [31:0] d,
                      output int waits, output logic [31:0] rdata,
                      output logic reop);
    logic acc, acc2;
    acc   = 1'b0;
    waits = 0;
    rdata = 32'hxxxxxxxx;
    reop  = 1'bx;
    obs_q.delete();
    drive(r, w, a, be, d);
    for (int n = 0; n < 40 && !acc; n++) begin
      step(acc);
      if (!acc) waits++;
    end
    chk("accept_bound", {31'b0, acc}, 32'd1);
    drive(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    if (r && !w) begin
      for (int n = 0; n < 20 && obs_q.size() == 0; n++) step(acc2);
      chk("response_bound", obs_q.size(), 32'd1);
      if (obs_q.size() > 0) begin
        rdata = obs_q[0].data;
        reop  = obs_q[0].eop;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_clear();
    for (int c = 0; c < 2; c++) begin
      rd_i[c] = 1'b0;
      wr_i[c] = 1'b0;
      ad_i[c] = 8'h00;
      be_i[c] = 4'h0;
      wd_i[c] = 32'h0;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic random_run(input int ncyc);
    logic        hold, r, w, acc;
    logic [5:0]  wsel;
    logic [7:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    int          k;
    hold = 1'b0;
    r    = 1'b0;
    w    = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (!hold) begin
        k = $urandom_range(0, 9);
        r = (k >= 3 && k <= 6) || k == 9;
        w = (k >= 7);
      end
      if (!hold || $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 7) == 0) wsel = 6'($urandom_range(18, 63));
        else wsel = 6'($urandom_range(0, 17));
        a  = {wsel, 2'($urandom_range(0, 3))};
        be = 4'($urandom_range(0, 15));
        d  = $urandom;
      end
      drive(r, w, a, be, d);
      step(acc);
      hold = (r | w) && !acc;
    end
    drive(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    repeat (8) step(acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          waits, stalls;
    logic [31:0] rdata, v1, v2;
    logic        reop, acc;

    n_cmp = 0;
    n_bad = 0;
    now   = 0;
    cur   = 0;

    tbl.push_back('{1'b0, 1'b1, 8'h0C, 4'hF, 32'h12345678, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h0C, 4'h0, 32'h0, 32'h12345678, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h3C, 4'hF, 32'hAABBCCDD, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h3C, 4'h1, 32'h00000011, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h3C, 4'h0, 32'h0, 32'hAABBCC11, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 8'h44, 4'h0, 32'h0, 32'h00020003, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h44, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h44, 4'h0, 32'h0, 32'h00000000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'hA0, 4'h0, 32'h0, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hA0, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'hA0, 4'h0, 32'h0, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h0B, 4'h6, 32'hCAFEBABE, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h09, 4'h0, 32'h0, 32'h00FEBA00, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h14, 4'hF, 32'h00000055, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h14, 4'h0, 32'h0, 32'h00000055, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h44, 4'h0, 32'h0, 32'h00050003, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h40, 4'hF, 32'h0, 32'h0, 1'b0});

    // Outputs and stall behaviour while held in reset.
    do_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cur = c;
      @(negedge clk);
      #1;
      chk("rst_waitreq_idle", {31'b0, wq_o[c]}, 32'd0);
      chk("rst_rdv", {31'b0, rdv_o[c]}, 32'd0);
      chk("rst_rdata", rdat_o[c], 32'd0);
      chk("rst_eop", {31'b0, eop_o[c]}, 32'd0);
      rd_i[c] = 1'b1;
      #1;
      chk("rst_waitreq_read", {31'b0, wq_o[c]}, 32'd1);
      rd_i[c] = 1'b0;
      wr_i[c] = 1'b1;
      #1;
      chk("rst_waitreq_write", {31'b0, wq_o[c]}, 32'd1);
      wr_i[c] = 1'b0;
    end

    // Directed table on the default configuration.
    cur = 0; ws = 2; rl = 2; mp = 4;
    do_reset();
    foreach (tbl[i]) begin
      xfer(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].d,
           waits, rdata, reop);
      chk($sformatf("tbl%0d_waits", i), waits, 32'd2);
      if (tbl[i].r && !tbl[i].w) begin
        chk($sformatf("tbl%0d_data", i), rdata, tbl[i].exp);
        chk($sformatf("tbl%0d_eop", i), {31'b0, reop},
            {31'b0, tbl[i].eop});
      end
    end
    xfer(1'b1, 1'b0, 8'h40, 4'h0, 32'h0, waits, v1, reop);
    xfer(1'b1, 1'b0, 8'h40, 4'h0, 32'h0, waits, v2, reop);
    chk("counter_increasing", {31'b0, v2 > v1}, 32'd1);

    // Reset one cycle after a read is accepted kills its response.
    xfer(1'b0, 1'b1, 8'h00, 4'hF, 32'h11112222, waits, rdata, reop);
    drive(1'b1, 1'b0, 8'h00, 4'h0, 32'h0);
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) step(acc);
    chk("midrst_accept", {31'b0, acc}, 32'd1);
    drive(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    step(acc);
    reset_n = 1'b0;
    model_clear();
    rd_i[0] = 1'b1;
    #1;
    chk("midrst_waitreq", {31'b0, wq_o[0]}, 32'd1);
    chk("midrst_rdv", {31'b0, rdv_o[0]}, 32'd0);
    rd_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_rdv_held", {31'b0, rdv_o[0]}, 32'd0);
    reset_n = 1'b1;
    repeat (6) step(acc);
    chk("midrst_no_stale", obs_q.size(), 32'd0);
    xfer(1'b1, 1'b0, 8'h00, 4'h0, 32'h0, waits, rdata, reop);
    chk("midrst_waits", waits, 32'd2);
    chk("midrst_word0", rdata, 32'h0);
    xfer(1'b1, 1'b0, 8'h0C, 4'h0, 32'h0, waits, rdata, reop);
    chk("midrst_word3", rdata, 32'h0);

    random_run(800);

    // Zero wait states, long latency, two outstanding reads.
    cur = 1; ws = 0; rl = 4; mp = 2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 1'b1, 8'(4 * i), 4'hF, 32'h100 + i, waits, rdata, reop);
      chk("ws0_write_waits", waits, 32'd0);
    end
    obs_q.delete();
    drive(1'b1, 1'b0, 8'h00, 4'h0, 32'h0);
    step(acc);
    chk("burst_rd0_acc", {31'b0, acc}, 32'd1);
    drive(1'b1, 1'b0, 8'h04, 4'h0, 32'h0);
    step(acc);
    chk("burst_rd1_acc", {31'b0, acc}, 32'd1);
    drive(1'b1, 1'b0, 8'h08, 4'h0, 32'h0);
    stalls = 0;
    acc    = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      step(acc);
      if (!acc) stalls++;
    end
    chk("burst_rd2_stalls", stalls, 32'd3);
    drive(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    repeat (8) step(acc);
    chk("burst_count", obs_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < obs_q.size())
        chk($sformatf("burst_order%0d", i), obs_q[i].data, 32'h100 + i);
    end

    random_run(800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
